// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
//   Definitions shared by the host command link, the command processor and the
//   host model.
//   - Command opcodes carried in byte 0 of every 3-byte host packet.
//   - The ACK response byte.
//   - The packet-assembly state type used by uart_cmd_wrapper.
// -----------------------------------------------------------------------------
package quad_pkg;

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_RLL   = 8'h03;
    localparam logic [7:0] SET_YW    = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] ACK       = 8'hA5;

    // Which packet byte the assembler expects next.
    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,    // waiting for the opcode byte
        PKT_HIGH = 2'd1,    // waiting for data[15:8]
        PKT_LOW  = 2'd2     // waiting for data[7:0]
    } pkt_state_t;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper_if
//   Bundle between uart_cmd_wrapper and the command processor.
//   master (wrapper)  : drives cmd, data, cmd_rdy, resp_sent, tx_busy, frame_err
//                       and receives clr_cmd_rdy, resp, send_resp.
//   slave  (consumer) : the mirror image.
// -----------------------------------------------------------------------------
interface uart_cmd_wrapper_if;

    logic [7:0]  cmd;          // opcode of last complete packet
    logic [15:0] data;         // payload of last complete packet
    logic        cmd_rdy;      // complete packet held in cmd/data
    logic        clr_cmd_rdy;  // consumer acknowledges cmd/data
    logic [7:0]  resp;         // response byte to transmit
    logic        send_resp;    // one-cycle start strobe for resp
    logic        resp_sent;    // one-cycle pulse at end of stop bit
    logic        tx_busy;      // transmitter active
    logic        frame_err;    // one-cycle pulse on a bad stop bit

    modport master (
        output cmd, data, cmd_rdy, resp_sent, tx_busy, frame_err,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, data, cmd_rdy, resp_sent, tx_busy, frame_err,
        output clr_cmd_rdy, resp, send_resp
    );

endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a 2-flop input synchronizer.
//   clk, rst_n : system clock, synchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   rx_data    : last received byte (valid while rx_rdy is high)
//   rx_rdy     : one-cycle pulse, byte received with a good stop bit
//   frame_err  : one-cycle pulse, stop bit sampled as 0 (byte dropped)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frame_err
);

    localparam int              CW   = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0]   FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   HALF = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_ff1, rx_ff2, rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronizer presets to the line's idle level so leaving reset
            // never looks like a falling (start) edge.
            rx_ff1    <= 1'b1;
            rx_ff2    <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_ff1    <= rx;
            rx_ff2    <= rx_ff1;
            rx_prev   <= rx_ff2;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_ff2)
                        state <= RX_START;
                end
                RX_START: begin
                    // Mid-start-bit re-check rejects glitches shorter than
                    // half a bit.
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_ff2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_ff2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin  // RX_STOP
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        state <= RX_IDLE;  // rearm right at the stop sample
                        if (rx_ff2)
                            rx_rdy <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_data = shift;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
//   Copter-side endpoint of the host command link.
//   clk, rst_n : 50 MHz system clock, synchronous active-low reset
//   RX         : serial input from host (8N1, idle high)
//   TX         : serial output to host (8N1, idle high)
//   bus        : command/response bundle (see uart_cmd_wrapper_if)
//   Received bytes are assembled into {cmd, data[15:8], data[7:0]} packets;
//   single response bytes are serialized on TX. RX and TX are independent.
// -----------------------------------------------------------------------------
module uart_cmd_wrapper
    import quad_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int TO_CYC   = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RX,
    output logic               TX,
    uart_cmd_wrapper_if.master bus
);

    localparam int            CW    = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] FULL  = CW'(BAUD_DIV - 1);
    localparam int            TW    = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_M1 = TW'(TO_CYC - 1);

    logic [7:0] rx_data;
    logic       rx_rdy;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (RX),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frame_err (bus.frame_err)
    );

    // ---------------- packet assembler ----------------
    pkt_state_t    pkt_state;
    logic [7:0]    pend_cmd;
    logic [7:0]    pend_hi;
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_state   <= PKT_IDLE;
            pend_cmd    <= '0;
            pend_hi     <= '0;
            to_cnt      <= '0;
            bus.cmd     <= '0;
            bus.data    <= '0;
            bus.cmd_rdy <= 1'b0;
        end else begin
            // NOTE: the clear is written first on purpose: a later
            // non-blocking write to cmd_rdy in the same edge overrides it,
            // which gives packet completion priority over clr_cmd_rdy.
            if (bus.clr_cmd_rdy)
                bus.cmd_rdy <= 1'b0;

            case (pkt_state)
                PKT_IDLE: begin
                    to_cnt <= '0;
                    if (rx_rdy) begin
                        pend_cmd    <= rx_data;
                        bus.cmd_rdy <= 1'b0;  // new packet supersedes old
                        pkt_state   <= PKT_HIGH;
                    end
                end
                default: begin  // PKT_HIGH, PKT_LOW
                    if (bus.frame_err) begin
                        to_cnt    <= '0;
                        pkt_state <= PKT_IDLE;
                    end else if (rx_rdy) begin
                        to_cnt <= '0;
                        if (pkt_state == PKT_HIGH) begin
                            pend_hi   <= rx_data;
                            pkt_state <= PKT_LOW;
                        end else begin
                            bus.cmd     <= pend_cmd;
                            bus.data    <= {pend_hi, rx_data};
                            bus.cmd_rdy <= 1'b1;
                            pkt_state   <= PKT_IDLE;
                        end
                    end else if (to_cnt == TO_M1) begin
                        // Host stalled mid-packet: drop the partial packet.
                        to_cnt    <= '0;
                        pkt_state <= PKT_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- transmitter ----------------
    // tx_shift holds the bits still to send after the current one; TX itself
    // is registered so the line is glitch-free.
    logic [8:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            TX            <= 1'b1;
            bus.tx_busy   <= 1'b0;
            bus.resp_sent <= 1'b0;
            tx_shift      <= '0;
            tx_cnt        <= '0;
            tx_bit        <= '0;
        end else begin
            bus.resp_sent <= 1'b0;
            if (!bus.tx_busy) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (bus.send_resp) begin
                    tx_shift    <= {1'b1, bus.resp};
                    TX          <= 1'b0;  // start bit
                    bus.tx_busy <= 1'b1;
                end
            end else if (tx_cnt == FULL) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    // End of stop bit.
                    TX            <= 1'b1;
                    bus.tx_busy   <= 1'b0;
                    bus.resp_sent <= 1'b1;
                end else begin
                    TX       <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
//   Directed bench for uart_cmd_wrapper with a short bit period and timeout.
// -----------------------------------------------------------------------------
module tb_uart_cmd_wrapper;

    localparam int B  = 16;
    localparam int TO = 2000;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;

    uart_cmd_wrapper_if bus ();

    uart_cmd_wrapper #(.BAUD_DIV(B), .TO_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (rx),
        .TX    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor: counts cmd_rdy rises and frame_err pulses, and records
    // when the last received byte and the last cmd_rdy rise occurred.
    int   cyc = 0;
    int   rdy_count = 0;
    int   fe_count = 0;
    int   last_rx_rdy_cyc = 0;
    int   last_rise_cyc = 0;
    logic cmd_rdy_d = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (dut.rx_rdy)
            last_rx_rdy_cyc = cyc;
        if (bus.cmd_rdy && !cmd_rdy_d) begin
            rdy_count++;
            last_rise_cyc = cyc;
        end
        cmd_rdy_d = bus.cmd_rdy;
        if (bus.frame_err)
            fe_count++;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo);
        send_byte(c, 1'b1);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
    endtask

    task automatic clear_rdy();
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
    endtask

    // Sends r and decodes TX at mid-bit. With poke set, a second strobe with a
    // different byte is issued mid-frame and must have no effect.
    task automatic tx_frame(input logic [7:0] r, input bit poke, input string tag);
        logic [9:0] bits;
        int n;
        int sent_at;
        int low_after;
        bits    = '0;
        n       = 0;
        sent_at = -1;
        @(negedge clk);
        bus.resp      = r;
        bus.send_resp = 1'b1;
        while (n < 12 * B && sent_at < 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.send_resp = 1'b0;
                check({tag, "_tx_low_1cyc"}, tx, 1'b0);
            end
            if (poke && n == 3 * B) begin
                bus.resp      = 8'h3C;
                bus.send_resp = 1'b1;
            end
            if (poke && n == 3 * B + 1)
                bus.send_resp = 1'b0;
            if (((n - 1) % B) == B / 2 && ((n - 1) / B) < 10)
                bits[(n - 1) / B] = tx;
            if (bus.resp_sent) begin
                sent_at = n;
                check({tag, "_busy_drop"}, bus.tx_busy, 1'b0);
            end
        end
        check({tag, "_resp_sent_cyc"}, sent_at, 10 * B + 1);
        check({tag, "_frame_bits"}, bits, {1'b1, r, 1'b0});
        @(negedge clk);
        check({tag, "_resp_sent_pulse"}, bus.resp_sent, 1'b0);
        if (poke) begin
            low_after = 0;
            repeat (3 * B) begin
                @(negedge clk);
                if (!tx) low_after++;
            end
            check({tag, "_no_extra_frame"}, low_after, 0);
        end
    endtask

    int rdy0, fe0;

    initial begin
        rst_n           = 1'b0;
        rx              = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        repeat (4) @(negedge clk);

        // Reset state
        check("rst_tx",        tx,            1'b1);
        check("rst_tx_busy",   bus.tx_busy,   1'b0);
        check("rst_cmd_rdy",   bus.cmd_rdy,   1'b0);
        check("rst_cmd",       bus.cmd,       8'h00);
        check("rst_data",      bus.data,      16'h0000);
        check("rst_resp_sent", bus.resp_sent, 1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (2 * B) @(negedge clk);

        // Single packet
        rdy0 = rdy_count;
        send_pkt(8'h05, 8'h00, 8'hFF);
        repeat (2) @(negedge clk);
        check("single_rdy",     bus.cmd_rdy, 1'b1);
        check("single_cmd",     bus.cmd,     8'h05);
        check("single_data",    bus.data,    16'h00FF);
        check("single_count",   rdy_count - rdy0, 1);
        check("single_latency", last_rise_cyc - last_rx_rdy_cyc, 1);
        clear_rdy();
        check("clr_rdy",        bus.cmd_rdy, 1'b0);
        check("clr_cmd_hold",   bus.cmd,     8'h05);
        check("clr_data_hold",  bus.data,    16'h00FF);

        // Supersede
        send_pkt(8'h02, 8'h01, 8'h00);
        repeat (2) @(negedge clk);
        check("sup1_rdy",  bus.cmd_rdy, 1'b1);
        check("sup1_cmd",  bus.cmd,     8'h02);
        check("sup1_data", bus.data,    16'h0100);
        send_byte(8'h07, 1'b1);
        check("sup_rdy_dropped", bus.cmd_rdy, 1'b0);
        check("sup_cmd_hold",    bus.cmd,     8'h02);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("sup2_rdy",  bus.cmd_rdy, 1'b1);
        check("sup2_cmd",  bus.cmd,     8'h07);
        check("sup2_data", bus.data,    16'h0000);

        // Timeout drops a partial packet
        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (TO + 10) @(negedge clk);
        rdy0 = rdy_count;
        send_pkt(8'h04, 8'h00, 8'h80);
        repeat (2) @(negedge clk);
        check("to_count", rdy_count - rdy0, 1);
        check("to_cmd",   bus.cmd,          8'h04);
        check("to_data",  bus.data,         16'h0080);

        // Framing error drops the packet
        rdy0 = rdy_count;
        fe0  = fe_count;
        send_byte(8'h08, 1'b1);
        send_byte(8'h12, 1'b0);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        send_byte(8'h34, 1'b1);
        repeat (2) @(negedge clk);
        check("fe_pulses",  fe_count - fe0,   1);
        check("fe_no_rdy",  rdy_count - rdy0, 0);
        check("fe_cmd",     bus.cmd,          8'h04);
        repeat (TO + 10) @(negedge clk);

        // Response, with an ignored mid-frame strobe
        tx_frame(8'hA5, 1'b1, "resp");

        // Full duplex
        clear_rdy();
        fork
            tx_frame(8'hA5, 1'b0, "dup");
            send_pkt(8'h06, 8'h00, 8'h00);
        join
        repeat (2) @(negedge clk);
        check("dup_rdy",  bus.cmd_rdy, 1'b1);
        check("dup_cmd",  bus.cmd,     8'h06);
        check("dup_data", bus.data,    16'h0000);

        // Reset mid-byte on RX and mid-frame on TX
        @(negedge clk);
        bus.resp      = 8'h5A;
        bus.send_resp = 1'b1;
        rx            = 1'b0;
        @(negedge clk);
        bus.send_resp = 1'b0;
        repeat (2 * B) @(negedge clk);
        rx = 1'b1;
        repeat (B) @(negedge clk);
        rx = 1'b0;
        repeat (B / 2) @(negedge clk);
        check("pre_rst_busy", bus.tx_busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx",        tx,            1'b1);
        check("mid_rst_busy",      bus.tx_busy,   1'b0);
        check("mid_rst_cmd_rdy",   bus.cmd_rdy,   1'b0);
        check("mid_rst_cmd",       bus.cmd,       8'h00);
        check("mid_rst_data",      bus.data,      16'h0000);
        check("mid_rst_resp_sent", bus.resp_sent, 1'b0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * B) @(negedge clk);
        send_pkt(8'h08, 8'h12, 8'h34);
        repeat (2) @(negedge clk);
        check("post_rst_rdy",  bus.cmd_rdy, 1'b1);
        check("post_rst_cmd",  bus.cmd,     8'h08);
        check("post_rst_data", bus.data,    16'h1234);
        check("post_rst_tx",   tx,          1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
